blink_counter: RTL and testbench
================================

# blink_counter

Parametrised, prescaled display counter that drives a bank of LEDs from the board clock. It is the generalised successor of the free-running top-level blinker:
- configurable count width and tick rate
- enable, synchronous load, and up/down/bounce/hold modes
- wrap/reversal event pulse
- optional PWM dimming

It sits between the board switches/buttons and the `led` pins in board top levels.

## Interface
- `BITS`, 4, display counter width (≥1)
- `LOG2DELAY`, 22, prescaler width; one step every 2^LOG2DELAY enabled cycles (≥1)

- `clk` in 1: board clock, all logic rising-edge
- `rst_n` in 1: reset, synchronous, active-low
- `en` in 1: prescaler advances only when 1
- `mode` in 2: 0 UP, 1 DOWN, 2 BOUNCE, 3 HOLD
- `load` in 1: synchronous load strobe
- `load_val` in BITS: value loaded into counter
- `duty` in 4: PWM duty in sixteenths; ignored unless PWM compiled in
- `count` out BITS: counter register
- `led` out BITS: LED drive
- `tick` out 1: one-cycle pulse, high in the cycle a new step result is visible on `count`
- `wrap` out 1: one-cycle pulse on wrap (UP/DOWN) or direction reversal (BOUNCE)

## Operation
- Prescaler `p` (LOG2DELAY bits): `p <= p+1` when `en`, modulo 2^LOG2DELAY. `step = en && p == all-ones`.
- Priority per edge: `!rst_n` > `load` > `step`.
- Load:
  - `count <= load_val`, `p <= 0`.
  - `tick`/`wrap` are 0 that cycle.
  - Direction register `dir` is unchanged.
- Step, per `mode` sampled at the step edge:
  - UP: `count+1` mod 2^BITS; `wrap` when max→0.
  - DOWN: `count-1` mod 2^BITS; `wrap` when 0→max.
  - BOUNCE, `dir` up: increment; at max, go to max-1, set `dir` down, pulse `wrap`.
  - BOUNCE, `dir` down: decrement; at 0, go to 1, set `dir` up, pulse `wrap`.
  - BOUNCE with BITS=1: toggles 0↔1 with `wrap` every step.
  - HOLD: `count` unchanged; `tick` still pulses; `wrap` 0.
- `dir` is modified only in BOUNCE. A mode change takes effect at the next step. Re-entering BOUNCE resumes the stored `dir`.
- `en`=0 freezes `p` with no steps. `load` is still honoured.
- Without PWM, `led = count`.

## Timing
- Reset values: `count`=0, `p`=0, `dir`=up, `tick`=0, `wrap`=0, `led`=0, PWM phase=0.
- `tick` and `wrap` are registered. They assert in the same cycle that `count` shows the stepped value.
- Step period is exactly 2^LOG2DELAY cycles of continuous `en`. The first step after reset or load occurs 2^LOG2DELAY enabled cycles later.
- `load` to `count` latency: 1 cycle.
- `rst_n` low mid-count: all state returns to reset values at that edge, regardless of `load`/`step`.

## Configuration
- `BLINK_COUNTER_PWM_EN` defined:
  - A free-running 4-bit phase counter runs from reset, independent of `en`.
  - `led <= count & {BITS{phase < duty}}` is registered, so it lags `count` by 1 cycle.
  - `duty`=0 gives LEDs dark; `duty`=15 gives 15/16 on-time.
- Undefined:
  - No phase counter.
  - `led = count` combinationally.
  - `duty` is unused.

## Structure
- Shared package `blink_pkg`:
  - Mode enum `blink_mode_e` (`MODE_UP`, `MODE_DOWN`, `MODE_BOUNCE`, `MODE_HOLD`)
  - Direction constants
- Sub-module `tick_gen`:
  - Parameter LOG2DELAY.
  - Ports `clk`, `rst_n`, `en`, `clr`.
  - Outputs the combinational `step`; owns `p`.
- Step/mode logic and PWM stay in `blink_counter`.

## Test plan
All scenarios use BITS=4, LOG2DELAY=2.
- Reset and UP: hold `rst_n`=0 for 3 cycles, then `en`=1, `mode`=UP.
  - `count` reads 1,2,3… every 4 cycles with `tick` on each.
  - After 64 cycles `count`=0 with `wrap`=1 exactly once.
- DOWN from reset: `mode`=DOWN.
  - First step gives `count`=15 with `wrap`=1, then 14, 13.
- BOUNCE: `load_val`=13, pulse `load`, then `mode`=BOUNCE.
  - Sequence is 14, 15, 14 (`wrap` on the 15→14 step), 13…
  - Then 1, 0, 1 (`wrap` on the 0→1 step).
- Load/step collision: assert `load` with `load_val`=9 on a step edge.
  - `count`=9, `tick`=0, `wrap`=0.
  - Next step occurs 4 cycles later and gives 10.
- HOLD and `en`:
  - `mode`=HOLD: `tick` pulses every 4 cycles and `count` is constant.
  - `en`=0 for 10 cycles: no `tick`, and `p` resumes from its frozen value.
- PWM, with `BLINK_COUNTER_PWM_EN` defined, `count`=15:
  - `duty`=4: `led`=15 for 4 of every 16 cycles.
  - `duty`=0: `led`=0 always.
  - Mid-run reset: `led`=0 the next cycle.

Source files
------------

// File: rtl/blink_counter_pkg.sv
// blink_pkg: shared mode enum and direction constants for blink_counter.
// Ports: none (package).
package blink_pkg;
  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } blink_mode_e;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/blink_counter_if.sv
// blink_counter_if: control/display bundle between the board top and blink_counter.
// Ports: en, mode, load, load_val, duty (master -> slave); count, led, tick, wrap (slave -> master).
interface blink_counter_if #(
  parameter int BITS = 4
) ();
  import blink_pkg::*;
  logic            en;
  blink_mode_e     mode;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [3:0]      duty;
  logic [BITS-1:0] count;
  logic [BITS-1:0] led;
  logic            tick;
  logic            wrap;
  modport master (output en, mode, load, load_val, duty, input count, led, tick, wrap);
  modport slave  (input en, mode, load, load_val, duty, output count, led, tick, wrap);
endinterface

// File: rtl/blink_counter_tick_gen.sv
// tick_gen: prescaler that fires a one-cycle step every 2^LOG2DELAY enabled cycles.
// Ports: clk, rst_n (sync, active-low), en (advance), clr (restart from 0), step (combinational).
module tick_gen #(
  parameter int LOG2DELAY = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);
  logic [LOG2DELAY-1:0] p_q;
  always_ff @(posedge clk) begin
    if (!rst_n) p_q <= '0;
    else if (clr) p_q <= '0;
    else if (en) p_q <= p_q + LOG2DELAY'(1);
  end
  assign step = en && (&p_q);
endmodule

// File: rtl/blink_counter.sv
// blink_counter: prescaled up/down/bounce/hold LED counter with wrap pulse and optional PWM.
// Ports: clk, rst_n (sync, active-low), bus (blink_counter_if.slave: en, mode, load,
// load_val, duty in; count, led, tick, wrap out).
// Optional PWM dimming is compiled in when BLINK_COUNTER_PWM_EN is defined.
module blink_counter
  import blink_pkg::*;
#(
  parameter int BITS      = 4,
  parameter int LOG2DELAY = 22
) (
  input logic           clk,
  input logic           rst_n,
  blink_counter_if.slave bus
);
  localparam logic [BITS-1:0] MAX = '1;
  logic            step;
  logic [BITS-1:0] count_q, count_d;
  logic            dir_q, dir_d;
  logic            tick_q, wrap_q, wrap_d;
  tick_gen #(.LOG2DELAY(LOG2DELAY)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bus.en),
    .clr  (bus.load),
    .step (step)
  );
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    case (bus.mode)
      MODE_UP: begin
        count_d = count_q + 1'b1;
        wrap_d  = count_q == MAX;
      end
      MODE_DOWN: begin
        count_d = count_q - 1'b1;
        wrap_d  = count_q == '0;
      end
      MODE_BOUNCE: begin
        // a 1-bit counter has no interior values, so every step is a reversal
        if (BITS == 1) begin
          count_d = ~count_q;
          dir_d   = count_q[0] ? DIR_DOWN : DIR_UP;
          wrap_d  = 1'b1;
        end else if (dir_q == DIR_UP) begin
          count_d = count_q == MAX ? MAX - 1'b1 : count_q + 1'b1;
          dir_d   = count_q == MAX ? DIR_DOWN : DIR_UP;
          wrap_d  = count_q == MAX;
        end else begin
          count_d = count_q == '0 ? BITS'(1) : count_q - 1'b1;
          dir_d   = count_q == '0 ? DIR_UP : DIR_DOWN;
          wrap_d  = count_q == '0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= step;
      wrap_q <= step && wrap_d;
      if (step) begin
        count_q <= count_d;
        dir_q   <= dir_d;
      end
    end
  end
  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;
`ifdef BLINK_COUNTER_PWM_EN
  // phase free-runs from reset regardless of en so brightness is steady while paused
  logic [3:0]      phase_q;
  logic [BITS-1:0] led_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      led_q   <= '0;
    end else begin
      phase_q <= phase_q + 4'd1;
      led_q   <= count_q & {BITS{phase_q < bus.duty}};
    end
  end
  assign bus.led = led_q;
`else
  logic unused_duty;
  assign unused_duty = ^bus.duty;
  assign bus.led     = count_q;
`endif
endmodule

// File: tb/tb_blink_counter.sv
// tb_blink_counter: self-checking bench for blink_counter (BITS=4, LOG2DELAY=2).
module tb_blink_counter;
  import blink_pkg::*;
  typedef struct {
    bit         r;
    bit         e;
    logic [1:0] m;
    bit         l;
    logic [3:0] lv;
    logic [3:0] d;
    int         n;
  } seg_t;
  typedef struct {
    int cnt;
    int tck;
    int wrp;
    int led;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  blink_counter_if #(.BITS(4)) bus ();
  blink_counter #(.BITS(4), .LOG2DELAY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   m_count = 0, m_p = 0, m_dir = 0, m_tick = 0, m_wrap = 0, m_phase = 0, m_led = 0;
  seg_t segs[10];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic cyc(input bit r, input bit e, input logic [1:0] m, input bit l,
                     input logic [3:0] lv, input logic [3:0] d);
    exp_t x;
    int   oc;
    bit   st;
    rst_n        = r;
    bus.en       = e;
    bus.mode     = blink_mode_e'(m);
    bus.load     = l;
    bus.load_val = lv;
    bus.duty     = d;
    oc = m_count;
    if (!r) begin
      m_count = 0; m_p = 0; m_dir = 0; m_tick = 0; m_wrap = 0; m_phase = 0; m_led = 0;
    end else begin
      m_led   = (m_phase < int'(d)) ? oc : 0;
      m_phase = (m_phase + 1) % 16;
      if (l) begin
        m_count = int'(lv); m_p = 0; m_tick = 0; m_wrap = 0;
      end else begin
        st = e && (m_p == 3);
        if (e) m_p = (m_p + 1) % 4;
        m_tick = st;
        m_wrap = 0;
        if (st) begin
          if (m == 2'd0) begin m_wrap = (oc == 15); m_count = (oc + 1) % 16; end
          else if (m == 2'd1) begin m_wrap = (oc == 0); m_count = (oc + 15) % 16; end
          else if (m == 2'd2) begin
            if (m_dir == 0) begin
              if (oc == 15) begin m_count = 14; m_dir = 1; m_wrap = 1; end
              else m_count = oc + 1;
            end else begin
              if (oc == 0) begin m_count = 1; m_dir = 0; m_wrap = 1; end
              else m_count = oc - 1;
            end
          end
        end
      end
    end
`ifdef BLINK_COUNTER_PWM_EN
    x = '{m_count, m_tick, m_wrap, m_led};
`else
    x = '{m_count, m_tick, m_wrap, m_count};
`endif
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("sb_count", int'(bus.count), x.cnt);
    chk("sb_tick", int'(bus.tick), x.tck);
    chk("sb_wrap", int'(bus.wrap), x.wrp);
    chk("sb_led", int'(bus.led), x.led);
  endtask
  task automatic run(input int n, input bit r, input bit e, input logic [1:0] m,
                     input bit l, input logic [3:0] lv, input logic [3:0] d);
    for (int i = 0; i < n; i++) cyc(r, e, m, l, lv, d);
  endtask
  initial begin
    int nw, nt, nl;
    segs[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd0, 3};
    segs[1] = '{1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 4'd0, 40};
    segs[2] = '{1'b1, 1'b1, 2'd2, 1'b1, 4'd2, 4'd0, 1};
    segs[3] = '{1'b1, 1'b1, 2'd2, 1'b0, 4'd0, 4'd0, 40};
    segs[4] = '{1'b1, 1'b1, 2'd3, 1'b0, 4'd0, 4'd0, 9};
    segs[5] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 4'd0, 10};
    segs[6] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'd7, 4'd0, 1};
    segs[7] = '{1'b1, 1'b1, 2'd0, 1'b0, 4'd0, 4'd0, 36};
    segs[8] = '{1'b1, 1'b1, 2'd2, 1'b0, 4'd0, 4'd0, 30};
    segs[9] = '{1'b0, 1'b1, 2'd0, 1'b1, 4'd5, 4'd0, 1};
    // reset then UP: one step per 4 cycles, a single wrap after 64 cycles
    run(3, 0, 0, 2'd0, 0, 0, 0);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_tick", int'(bus.tick), 0);
    nw = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc(1, 1, 2'd0, 0, 0, 0);
      if (bus.wrap) nw++;
      if (i % 4 == 0) begin
        chk("up_count", int'(bus.count), (i / 4) % 16);
        chk("up_tick", int'(bus.tick), 1);
      end
    end
    chk("up_wrap_once", nw, 1);
    chk("up_wrap_last", int'(bus.wrap), 1);
    // DOWN from reset: 15 with wrap, then 14, 13
    run(1, 0, 0, 2'd1, 0, 0, 0);
    run(4, 1, 1, 2'd1, 0, 0, 0);
    chk("down_first", int'(bus.count), 15);
    chk("down_wrap", int'(bus.wrap), 1);
    run(4, 1, 1, 2'd1, 0, 0, 0);
    chk("down_14", int'(bus.count), 14);
    chk("down_14_wrap", int'(bus.wrap), 0);
    run(4, 1, 1, 2'd1, 0, 0, 0);
    chk("down_13", int'(bus.count), 13);
    // BOUNCE from 13: 14, 15, 14 (wrap), 13 ... 1, 0, 1 (wrap)
    run(1, 0, 0, 2'd2, 0, 0, 0);
    cyc(1, 1, 2'd2, 1, 4'd13, 0);
    chk("load_13", int'(bus.count), 13);
    run(4, 1, 1, 2'd2, 0, 0, 0);
    chk("bounce_14", int'(bus.count), 14);
    run(4, 1, 1, 2'd2, 0, 0, 0);
    chk("bounce_15", int'(bus.count), 15);
    chk("bounce_15_wrap", int'(bus.wrap), 0);
    run(4, 1, 1, 2'd2, 0, 0, 0);
    chk("bounce_rev_hi", int'(bus.count), 14);
    chk("bounce_rev_hi_wrap", int'(bus.wrap), 1);
    run(56, 1, 1, 2'd2, 0, 0, 0);
    chk("bounce_0", int'(bus.count), 0);
    chk("bounce_0_wrap", int'(bus.wrap), 0);
    run(4, 1, 1, 2'd2, 0, 0, 0);
    chk("bounce_rev_lo", int'(bus.count), 1);
    chk("bounce_rev_lo_wrap", int'(bus.wrap), 1);
    // load colliding with a step edge wins, then the prescaler restarts
    run(1, 0, 0, 2'd0, 0, 0, 0);
    run(3, 1, 1, 2'd0, 0, 0, 0);
    cyc(1, 1, 2'd0, 1, 4'd9, 0);
    chk("coll_count", int'(bus.count), 9);
    chk("coll_tick", int'(bus.tick), 0);
    chk("coll_wrap", int'(bus.wrap), 0);
    run(3, 1, 1, 2'd0, 0, 0, 0);
    chk("coll_wait_count", int'(bus.count), 9);
    cyc(1, 1, 2'd0, 0, 0, 0);
    chk("coll_next", int'(bus.count), 10);
    chk("coll_next_tick", int'(bus.tick), 1);
    // HOLD keeps count with ticks; en=0 freezes the prescaler mid-period
    cyc(1, 1, 2'd3, 1, 4'd5, 0);
    run(4, 1, 1, 2'd3, 0, 0, 0);
    chk("hold_tick", int'(bus.tick), 1);
    chk("hold_count", int'(bus.count), 5);
    run(2, 1, 1, 2'd3, 0, 0, 0);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 2'd3, 0, 0, 0);
      if (bus.tick) nt++;
    end
    chk("en0_no_tick", nt, 0);
    cyc(1, 1, 2'd3, 0, 0, 0);
    chk("resume_1", int'(bus.tick), 0);
    cyc(1, 1, 2'd3, 0, 0, 0);
    chk("resume_2", int'(bus.tick), 1);
    chk("resume_count", int'(bus.count), 5);
    // table-driven segments checked against the scoreboard model
    foreach (segs[k]) run(segs[k].n, segs[k].r, segs[k].e, segs[k].m, segs[k].l, segs[k].lv, segs[k].d);
    chk("tbl_reset_count", int'(bus.count), 0);
`ifdef BLINK_COUNTER_PWM_EN
    cyc(1, 1, 2'd3, 1, 4'd15, 4'd4);
    cyc(1, 1, 2'd3, 0, 0, 4'd4);
    nl = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, 2'd3, 0, 0, 4'd4);
      if (bus.led == 4'd15) nl++;
    end
    chk("pwm_duty4", nl, 8);
    nl = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 2'd3, 0, 0, 4'd0);
      if (bus.led != 4'd0) nl++;
    end
    chk("pwm_duty0", nl, 0);
    run(5, 1, 1, 2'd3, 0, 0, 4'd15);
    cyc(0, 1, 2'd3, 0, 0, 4'd15);
    chk("pwm_reset_led", int'(bus.led), 0);
`else
    nl = 0;
    chk("led_eq_count", int'(bus.led), int'(bus.count));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
